trap_redirect_unit: RTL
=======================

Name: trap_redirect_unit

Overview:
- Consumer end of the CSR stage interface: takes the registered CSR command and trap vector at writeback, plus branch decisions, and generates the pipeline redirect.
- Generates `wb_branch_hazard` back into the CSR and earlier stages, and issues a valid/ready redirect to fetch.
- Owns `mepc` and a trap counter.
- Sequences squash of wrong-path instructions with a small FSM.

Parameters:
- FLUSH_CYCLES, 3, cycles `wb_branch_hazard` stays high after the redirect is accepted (stages ahead of WB to squash); 0 is legal.
- XLEN, 32, data/address width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- wb_valid  in  1  instruction present at WB this cycle
- wb_pc  in  XLEN  PC of the WB instruction
- csr_cmd  in  3  registered CSR command from the CSR stage (CSR_X/W/S/C/ECALL/MRET)
- trap_vector  in  XLEN  current mtvec from the CSR stage
- br_flg  in  1  taken branch/jump resolved at WB
- br_target  in  XLEN  branch target
- redirect_ready  in  1  fetch accepts redirect
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  XLEN  new fetch PC, stable while redirect_valid
- wb_branch_hazard  out  1  squash signal to CSR/EXE/ID stages
- mepc  out  XLEN  saved exception PC
- trap_count  out  32  number of ECALLs taken, wraps at 2^32

Behaviour:
- Reset (async, immediate) state:
  - state=IDLE
  - redirect_valid=0, wb_branch_hazard=0, redirect_pc=0
  - mepc=0, trap_count=0, flush counter=0
- All outputs are registered; no combinational input-to-output path.
- States:
  - IDLE: no redirect pending.
  - REDIRECT: redirect_valid=1, wb_branch_hazard=1.
  - FLUSH: redirect_valid=0, wb_branch_hazard=1.
- Event selection is evaluated in IDLE at the posedge when wb_valid=1. Priority, highest first:
  1. csr_cmd==CSR_ECALL: target=trap_vector; mepc<=wb_pc; trap_count<=trap_count+1.
  2. csr_cmd==CSR_MRET: target=mepc (the value before this edge).
  3. br_flg=1: target=br_target.
  4. Otherwise: stay in IDLE, no output change.
- On any event: redirect_pc<=target, redirect_valid<=1, wb_branch_hazard<=1, state<=REDIRECT. Latency is 1 cycle from the WB event to redirect_valid.
- REDIRECT:
  - Hold redirect_valid and redirect_pc until a posedge with redirect_ready=1.
  - On that edge: redirect_valid<=0.
  - If FLUSH_CYCLES==0: wb_branch_hazard<=0, state<=IDLE.
  - Else: counter<=FLUSH_CYCLES-1, state<=FLUSH.
- FLUSH:
  - If counter==0: wb_branch_hazard<=0, state<=IDLE.
  - Else: counter decrements.
  - Hazard is therefore high for exactly FLUSH_CYCLES cycles after acceptance.
- While state!=IDLE, wb_valid/csr_cmd/br_flg are ignored: wrong-path instructions cause no state change, no mepc or trap_count update.
- redirect_ready=1 in the same cycle redirect_valid rises counts as acceptance at the next edge (one-cycle minimum REDIRECT).
- redirect_ready while in IDLE or FLUSH has no effect.
- ECALL and br_flg together: ECALL wins; br_target is discarded.
- MRET immediately after an ECALL redirect completes uses the updated mepc.
- Reset asserted mid-REDIRECT or mid-FLUSH aborts the sequence: redirect_valid and hazard drop asynchronously.
- trap_count wraps 0xFFFFFFFF -> 0.
- Counter width: $clog2(FLUSH_CYCLES+1), minimum 1.

Decomposition:
- Add CSR_MRET to the shared CSR command constants in include/core.v, alongside CSR_X/W/S/C/ECALL. Its encoding must be unused by existing commands.
- FSM state encodings are local parameters.
- One natural sub-module, flush_counter:
  - Load on acceptance, decrement, and assert done at zero.
  - Used only when FLUSH_CYCLES>0.

Test Plan:
- Reset, then drive nothing:
  - redirect_valid=0, wb_branch_hazard=0, mepc=0, trap_count=0 for 10 cycles.
- ECALL with wb_pc=0x100, trap_vector=0x800, redirect_ready=1:
  - Next cycle redirect_valid=1, redirect_pc=0x800, mepc=0x100, trap_count=1.
  - Hazard high for 1+3 cycles, then IDLE.
- Taken branch br_target=0x40 with redirect_ready held 0 for 5 cycles:
  - redirect_valid and redirect_pc=0x40 stay stable for 5 cycles.
  - Then hazard stays high 3 more cycles after acceptance.
- ECALL at 0x200, then MRET after return to IDLE:
  - Second redirect_pc=0x200.
  - A br_flg=1 pulse during FLUSH is ignored (no extra redirect).
- ECALL with br_flg=1, br_target=0x44, trap_vector=0x900 in the same cycle:
  - redirect_pc=0x900.
- Assert rst two cycles into FLUSH:
  - Hazard and redirect_valid drop immediately, mepc=0.
  - The next branch after reset is accepted normally.
- With FLUSH_CYCLES=0 as a second configuration:
  - Hazard drops on the edge after acceptance.

Source files
------------

// File: rtl/trap_redirect_unit_pkg.sv
`default_nettype none
// ============================================================================
// trap_redirect_unit_pkg -- CSR command encodings and redirect FSM states
// Revision: 1.0
// ============================================================================
package trap_redirect_unit_pkg;

    localparam logic [2:0] CSR_X     = 3'd0;
    localparam logic [2:0] CSR_W     = 3'd1;
    localparam logic [2:0] CSR_S     = 3'd2;
    localparam logic [2:0] CSR_C     = 3'd3;
    localparam logic [2:0] CSR_ECALL = 3'd4;
    localparam logic [2:0] CSR_MRET  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/trap_redirect_unit_flush_counter.sv
`default_nettype none
// ============================================================================
// trap_redirect_unit_flush_counter -- loadable down-counter, done at zero
// Revision: 1.0
// ============================================================================
module trap_redirect_unit_flush_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule
`default_nettype wire

// File: rtl/trap_redirect_unit.sv
`default_nettype none
// ============================================================================
// trap_redirect_unit -- WB-stage trap/branch redirect with squash sequencing
// Revision: 1.0
// ============================================================================
module trap_redirect_unit
    import trap_redirect_unit_pkg::*;
#(
    parameter int FLUSH_CYCLES = 3,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [XLEN-1:0] wb_pc,
    input  logic [2:0]      csr_cmd,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            br_flg,
    input  logic [XLEN-1:0] br_target,
    input  logic            redirect_ready,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            wb_branch_hazard,
    output logic [XLEN-1:0] mepc,
    output logic [31:0]     trap_count
);

    localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    state_t state;
    logic   accept;
    logic   flush_done;

    assign accept = (state == ST_REDIRECT) && redirect_ready;

    generate
        if (FLUSH_CYCLES > 0) begin : g_flush
            localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(FLUSH_CYCLES - 1);

            trap_redirect_unit_flush_counter #(
                .WIDTH (CNT_W)
            ) u_flush_counter (
                .clk        (clk),
                .rst        (rst),
                .load       (accept),
                .load_value (LOAD_VALUE),
                .dec        (state == ST_FLUSH),
                .done       (flush_done)
            );
        end else begin : g_no_flush
            assign flush_done = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            wb_branch_hazard <= 1'b0;
            mepc             <= '0;
            trap_count       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // ECALL outranks MRET outranks a taken branch
                    if (wb_valid && ((csr_cmd == CSR_ECALL) || (csr_cmd == CSR_MRET) || br_flg)) begin
                        redirect_valid   <= 1'b1;
                        wb_branch_hazard <= 1'b1;
                        state            <= ST_REDIRECT;
                        if (csr_cmd == CSR_ECALL) begin
                            redirect_pc <= trap_vector;
                            mepc        <= wb_pc;
                            trap_count  <= trap_count + 32'd1;
                        end else if (csr_cmd == CSR_MRET) begin
                            redirect_pc <= mepc;
                        end else begin
                            redirect_pc <= br_target;
                        end
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        if (FLUSH_CYCLES == 0) begin
                            wb_branch_hazard <= 1'b0;
                            state            <= ST_IDLE;
                        end else begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_done) begin
                        wb_branch_hazard <= 1'b0;
                        state            <= ST_IDLE;
                    end
                end
                default: begin
                    redirect_valid   <= 1'b0;
                    wb_branch_hazard <= 1'b0;
                    state            <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
